muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer that sits in the execute stage alongside the ALU. It accepts one M-extension operation from decode/execute and runs a shift-add multiply or a restoring divide over XLEN cycles. While it runs, it stalls the pipeline and presents a registered result with a one-cycle done pulse. Branch redirect or exception flush aborts an in-flight operation.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  execute-stage M-op valid; sampled only in IDLE.
funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
op_a  input  XLEN  rs1 value, captured on accept.
op_b  input  XLEN  rs2 value, captured on accept.
flush  input  1  synchronous abort (branch taken, jump, trap).
busy  output  1  high in CALC and DONE.
stall  output  1  hold upstream pipeline registers.
done  output  1  one-cycle pulse; result valid this cycle.
result  output  XLEN  registered result; held until next accept.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, stall=0, result=0, counter=0, internal accumulators=0. Reset mid-operation discards the operation; no done follows.
- States: IDLE, CALC, DONE.
- IDLE: accept = start & !flush. On accept, latch funct3, |op_a|, |op_b|, sign flags, and special-case flags.
  - Normal op: go to CALC with counter=0.
  - Special op: go directly to DONE with the special result loaded.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats op_a as signed and op_b as unsigned. MULHU/DIVU/REMU treat both as unsigned.
- Special cases, decided at accept:
  - Divide by zero (op_b=0, funct3 4-7): DIV/DIVU result=all ones; REM/REMU result=op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- CALC: one iteration per cycle; counter increments; leave to DONE when counter==XLEN-1.
  - Multiply: shift-add on magnitudes into a 2*XLEN product.
  - Divide: restoring shift-subtract on magnitudes, producing quotient and remainder.
- Entering DONE, apply signs and select the output:
  - Product negated if the operand signs differ (signed ops only).
  - Quotient sign = sa^sb.
  - Remainder sign = sa.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
  - result register loads on the CALC->DONE transition.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start in DONE is ignored.
- Latency from accept edge to done high:
  - Normal: XLEN+1 cycles (33 for XLEN=32).
  - Special: 1 cycle.
- stall = (IDLE & start & !flush) | CALC. stall is 0 in DONE, so the pipeline advances at the end of the DONE cycle and consumes result.
- busy=1 in CALC and DONE; busy=0 in IDLE.
- start while in CALC or DONE: ignored, no side effects.
- flush:
  - In CALC or DONE: next state IDLE, done suppressed, result keeps its previous value.
  - flush & start in the same IDLE cycle: flush wins; not accepted; stall=0.
- result changes only on the CALC->DONE transition, on a special-case accept, or on reset.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> stall high 33 cycles; done pulse at accept+33; result=0xFFFFFFEB; busy low next cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. All complete at accept+33.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF with done at accept+1.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at accept+1.
  - REM same operands -> 0.
- Flush and start interactions:
  - Flush at CALC cycle 10 -> IDLE next cycle; no done; result unchanged; a following accepted MUL 3*4 -> 12.
  - start pulsed during CALC is ignored.
  - start & flush in IDLE -> no accept.
- Assert rst_n low at CALC cycle 5 -> outputs zero immediately (async); no done after release; next op completes normally.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// Shift-add multiply / restoring divide over XLEN cycles, flushable.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              sgn_a, sgn_b;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   spec_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh, div_dif;
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   fin;

  assign accept = (state_q == S_IDLE) & start & ~flush;

  // Decode operand signedness, magnitudes and accept-time special cases
  always_comb begin
    sgn_a    = (funct3 == 3'd0) | (funct3 == 3'd1) | (funct3 == 3'd2)
             | (funct3 == 3'd4) | (funct3 == 3'd6);
    sgn_b    = (funct3 == 3'd0) | (funct3 == 3'd1)
             | (funct3 == 3'd4) | (funct3 == 3'd6);
    a_neg    = sgn_a & op_a[XLEN-1];
    b_neg    = sgn_b & op_b[XLEN-1];
    a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
    div_zero = funct3[2] & (op_b == '0);
    div_ovf  = funct3[2] & ~funct3[0]
             & (op_a == MIN_NEG) & (&op_b);
    if (div_zero) begin
      spec_res = funct3[1] ? op_a : '1;
    end else begin
      spec_res = funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step plus sign fix-up and output select for the last step
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
            + (acc_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_dif = div_sh - {1'b0, b_q};
    if (!f3_q[2]) begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end else if (div_dif[XLEN]) begin
      step = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step = {div_dif[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    prod_s = (sa_q ^ sb_q) ? (~step + 1'b1) : step;
    quo_s  = (sa_q ^ sb_q) ? (~step[XLEN-1:0] + 1'b1)
                           : step[XLEN-1:0];
    rem_s  = sa_q ? (~step[2*XLEN-1:XLEN] + 1'b1)
                  : step[2*XLEN-1:XLEN];
    if (f3_q == 3'd0) begin
      fin = prod_s[XLEN-1:0];
    end else if (!f3_q[2]) begin
      fin = prod_s[2*XLEN-1:XLEN];
    end else if (!f3_q[1]) begin
      fin = quo_s;
    end else begin
      fin = rem_s;
    end
  end

  // Sequencer next-state: accept, iterate, present result, abort on flush
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d   = funct3;
          b_d    = b_mag;
          sa_d   = a_neg;
          sb_d   = b_neg;
          busy_d = 1'b1;
          if (div_zero | div_ovf) begin
            state_d = S_DONE;
            res_d   = spec_res;
            done_d  = 1'b1;
          end else begin
            state_d = S_CALC;
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, a_mag};
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_DONE;
            res_d   = fin;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q & ~flush;
  assign stall  = accept | (state_q == S_CALC);
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq.
// Driver pushes expected result/time, monitor pops on done.
module tb_muldiv_seq;

  localparam int P = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, stall, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    longint      t;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .stall(stall),
    .done(done), .result(result)
  );

  always #(P/2) clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(logic [2:0] f,
                                        logic [31:0] a,
                                        logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    if (f < 3'd4) begin
      if (f == 3'd3) p = ua * ub;
      else if (f == 3'd2) p = sa * ub;
      else p = sa * sb;
      return (f == 3'd0) ? p[31:0] : p[63:32];
    end
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (f == 3'd4) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
      return ia / ib;
    end
    if (f == 3'd6) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return ia % ib;
    end
    if (f == 3'd5) return a / b;
    return a % b;
  endfunction

  function automatic bit is_special(logic [2:0] f,
                                    logic [31:0] a,
                                    logic [31:0] b);
    if (f < 3'd4) return 0;
    if (b == 0) return 1;
    return (f == 3'd4 || f == 3'd6)
        && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("done_time", $time, e.t);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sbq.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", sbq.size(), 0);
  endtask

  task automatic issue(logic [2:0] f, logic [31:0] a,
                       logic [31:0] b, logic [31:0] exp, bit push);
    exp_t e;
    int lat;
    wait_idle();
    funct3 = f;
    op_a = a;
    op_b = b;
    start = 1'b1;
    @(posedge clk);
    lat = is_special(f, a, b) ? 1 : 33;
    if (push) begin
      e.res = exp;
      e.t = longint'($time) + (lat - 1) * P + P / 2;
      sbq.push_back(e);
      last_res = exp;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [2:0]  d_f[14] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6,
                           3'd5, 3'd7, 3'd5, 3'd6, 3'd4,
                           3'd6, 3'd7, 3'd4, 3'd0};
  logic [31:0] d_a[14] = '{32'h8000_0000, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'hFFFF_FFF9,
                           32'hFFFF_FFF9, 32'd100, 32'd100,
                           32'd5, 32'd5, 32'h8000_0000,
                           32'h8000_0000, 32'd9, 32'd9,
                           32'h8000_0000};
  logic [31:0] d_b[14] = '{32'h8000_0000, 32'hFFFF_FFFF,
                           32'hFFFF_FFFF, 32'd2, 32'd2,
                           32'd7, 32'd7, 32'd0, 32'd0,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'd0, 32'd0, 32'd3};
  logic [31:0] d_e[14] = '{32'h4000_0000, 32'hFFFF_FFFE,
                           32'hFFFF_FFFF, 32'hFFFF_FFFD,
                           32'hFFFF_FFFF, 32'd14, 32'd2,
                           32'hFFFF_FFFF, 32'd5,
                           32'h8000_0000, 32'd0, 32'd9,
                           32'hFFFF_FFFF, 32'h8000_0000};

  initial begin
    #(1_000_000);
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [2:0] f;
    logic [31:0] a, b;
    exp_t e;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_result", result, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // MUL 7 * -3 with stall count
    wait_idle();
    funct3 = 3'd0;
    op_a = 32'd7;
    op_b = 32'hFFFF_FFFD;
    start = 1'b1;
    #1;
    chk("stall_accept", stall, 1);
    n = 1;
    @(posedge clk);
    e.res = 32'hFFFF_FFEB;
    e.t = longint'($time) + 32 * P + P / 2;
    sbq.push_back(e);
    last_res = e.res;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (stall) n++;
    end
    chk("stall_cycles", n, 33);
    @(negedge clk);
    chk("busy_after_done", busy, 0);

    foreach (d_f[i]) issue(d_f[i], d_a[i], d_b[i], d_e[i], 1);
    wait_drain();

    // flush at CALC cycle 10
    issue(3'd0, 32'h1234, 32'h5678, 0, 0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_no_done", done, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_result", result, last_res);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 32'd12, 1);
    wait_drain();

    // start pulsed during CALC must be ignored
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1);
    repeat (5) @(negedge clk);
    funct3 = 3'd7;
    op_a = 32'd9;
    op_b = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (5) @(negedge clk);

    // start and flush together in IDLE
    wait_idle();
    funct3 = 3'd5;
    op_a = 32'd9;
    op_b = 32'd0;
    start = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_start_stall", stall, 0);
    @(negedge clk);
    chk("flush_start_busy", busy, 0);
    start = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk);

    // async reset in CALC cycle 5
    issue(3'd0, 32'hDEAD, 32'hBEEF, 0, 0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_stall", stall, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);
    wait_drain();

    // random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(f, a, b, model(f, a, b), 1);
    end
    wait_drain();
    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
